fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the PC datapath against a variable-latency instruction memory.
//  Drives the PC register enable and the next-PC select, and issues fetch requests at pc_in.
//  Holds a returned instruction while decode stalls.
//  Absorbs execute-stage redirects (branch/jump), including redirects that arrive while a fetch is in flight.
// PARAMETERS
//  WIDTH      32            datapath/address width
//  CNT_WIDTH  32            width of fetch_count
// PORTS
//  clk              in   1          clock
//  rst              in   1          reset, asynchronous, active-high
//  pc_in            in   WIDTH      current PC (PC register output)
//  pc_en            out  1          PC register write enable
//  pc_src           out  1          next-PC select: 0 = PC+4, 1 = pc_target
//  pc_target        out  WIDTH      redirect target routed to the PC target input
//  redirect_valid   in   1          1-cycle redirect pulse from execute
//  redirect_target  in   WIDTH      redirect address, valid with redirect_valid
//  stall            in   1          decode cannot accept an instruction this cycle
//  imem_req         out  1          fetch request; held high until imem_ready
//  imem_addr        out  WIDTH      fetch address (= pc_in)
//  imem_ready       in   1          instruction memory response valid
//  imem_rdata       in   WIDTH      instruction memory response data
//  instr_valid      out  1          instr_out/instr_pc valid; consumed when instr_valid & !stall
//  instr_out        out  WIDTH      instruction to decode
//  instr_pc         out  WIDTH      PC of instr_out
//  fetch_count      out  CNT_WIDTH  number of instructions consumed by decode
// BEHAVIOUR
//  Reset (async): state=IDLE, hold_q=NOP (32'h00000013), redir_q=0, fetch_count=0.
//   All outputs are 0 while in IDLE, except instr_out, which is NOP.
//  Reset mid-fetch: any in-flight response is ignored; the first request after reset is issued at the reset-time pc_in.
//  IDLE -> REQ unconditionally after 1 cycle.
//   redirect_valid in IDLE: pc_en=1, pc_src=1, pc_target=redirect_target.
//  REQ: imem_req=1, imem_addr=pc_in. Response path is combinational: instr_out=imem_rdata, instr_pc=pc_in.
//   ready & !redirect & !stall: instr_valid=1, pc_en=1, pc_src=0, fetch_count++, stay REQ.
//   ready & !redirect & stall: instr_valid=1, hold_q<=imem_rdata, pc_en=0 -> HOLD.
//   ready & redirect: instr_valid=0 (response dropped), pc_en=1, pc_src=1, pc_target=redirect_target -> REQ.
//   !ready & redirect: redir_q<=redirect_target -> DROP. PC unchanged.
//  HOLD: imem_req=0, instr_valid=1, instr_out=hold_q, instr_pc=pc_in (PC has not advanced).
//   !stall & !redirect: pc_en=1, pc_src=0, fetch_count++ -> REQ.
//   redirect (regardless of stall): instr_valid=0, pc_en=1, pc_src=1, pc_target=redirect_target -> REQ.
//  DROP: imem_req=1 at the same address until the outstanding beat retires; instr_valid=0.
//   redirect: redir_q<=redirect_target (latest wins).
//   ready: pc_en=1, pc_src=1, pc_target = redirect_valid ? redirect_target : redir_q -> REQ.
//  Priority: redirect > stall > normal advance. A redirect never lets a stale instruction reach decode.
//  pc_target outside a redirect cycle is redir_q (don't-care, since pc_src=0).
//  pc_en, pc_src, pc_target, imem_*, instr_* are combinational from state and inputs.
//   Only state, hold_q, redir_q and fetch_count are registered.
//  fetch_count wraps modulo 2^CNT_WIDTH with no saturation.
//  imem_addr is passed through unaligned; alignment is the PC datapath's responsibility.
// STRUCTURE
//  fetch_pkg: enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
//   localparam NOP_INSTR = 32'h00000013.
//  Single always_ff for state/hold_q/redir_q/fetch_count; single always_comb for next state and outputs.
//  No sub-module: the hold register and the redirect latch are inline. The PC register/mux stays external.
// TESTING
//  1 rst=1 then release, pc_in=0, imem_ready=1 every cycle, stall=0:
//    IDLE 1 cycle, then instr_valid=1 with pc_en=1 each cycle; fetch_count 0->1->2->3 over 3 cycles.
//  2 REQ, imem_ready=1, rdata=32'h00500093, stall=1 for 3 cycles:
//    HOLD with instr_out=32'h00500093 and pc_en=0 throughout; on stall=0, pc_en=1 and fetch_count+1.
//  3 REQ, imem_ready=0, redirect_valid=1 target=32'h100; ready after 2 cycles:
//    DROP, instr_valid=0, then pc_en=1, pc_src=1, pc_target=32'h100 on the ready cycle.
//  4 In DROP, a second redirect to 32'h200 before ready:
//    pc_target=32'h200 on the ready cycle; 32'h100 is never applied.
//  5 HOLD with stall=1 and redirect_valid=1 target=32'h40:
//    instr_valid=0, pc_en=1, pc_src=1, pc_target=32'h40; next state REQ; fetch_count unchanged.
//  6 fetch_count preset near max (force 32'hFFFFFFFF), one consumed fetch -> 32'h0.
//    Assert rst while imem_req=1 -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the external PC register against a variable-latency
// instruction memory, parks responses while decode stalls, and absorbs redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pc_in,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [WIDTH-1:0]     pc_target,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_target,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [WIDTH-1:0]     imem_addr,
    input  logic                 imem_ready,
    input  logic [WIDTH-1:0]     imem_rdata,
    output logic                 instr_valid,
    output logic [WIDTH-1:0]     instr_out,
    output logic [WIDTH-1:0]     instr_pc,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [WIDTH-1:0]     hold_q;
    logic [WIDTH-1:0]     redir_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic hold_load;
    logic redir_load;
    logic consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hold_q  <= WIDTH'(NOP_INSTR);
            redir_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_q <= imem_rdata;
            end
            if (redir_load) begin
                redir_q <= redirect_target;
            end
            if (consume) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid) begin
                    // A redirect with no response yet must wait out the in-flight beat.
                    state_nxt = imem_ready ? REQ : DROP;
                end else if (imem_ready && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (imem_ready) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        pc_target   = redir_q;
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        instr_out   = imem_rdata;
        instr_pc    = '0;
        hold_load   = 1'b0;
        redir_load  = 1'b0;
        consume     = 1'b0;

        unique case (state)
            IDLE: begin
                instr_out = WIDTH'(NOP_INSTR);
                if (redirect_valid) begin
                    pc_en     = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = redirect_target;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                instr_pc  = pc_in;
                if (imem_ready) begin
                    if (redirect_valid) begin
                        pc_en     = 1'b1;
                        pc_src    = 1'b1;
                        pc_target = redirect_target;
                    end else begin
                        instr_valid = 1'b1;
                        if (stall) begin
                            hold_load = 1'b1;
                        end else begin
                            pc_en   = 1'b1;
                            consume = 1'b1;
                        end
                    end
                end else if (redirect_valid) begin
                    redir_load = 1'b1;
                end
            end
            HOLD: begin
                imem_addr = pc_in;
                instr_out = hold_q;
                instr_pc  = pc_in;
                if (redirect_valid) begin
                    pc_en     = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = redirect_target;
                end else begin
                    instr_valid = 1'b1;
                    if (!stall) begin
                        pc_en   = 1'b1;
                        consume = 1'b1;
                    end
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                instr_pc  = pc_in;
                if (redirect_valid) begin
                    redir_load = 1'b1;
                end
                // A redirect landing on the retiring beat beats the latched one.
                if (imem_ready) begin
                    pc_en     = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = redirect_valid ? redirect_target : redir_q;
                end
            end
            default: begin
                instr_out = WIDTH'(NOP_INSTR);
            end
        endcase
    end

    assign fetch_count = count_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed steps push expected PC/decode events,
// a negedge monitor pops and compares whenever instr_valid or pc_en is seen.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_en;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] fetch_count;

    fetch_ctrl #(.WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_src(pc_src),
        .pc_target(pc_target), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .stall(stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        v;
        logic        en;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] out;
        logic [31:0] ipc;
        logic [31:0] cnt;
    } ev_t;

    ev_t         sb[$];
    ev_t         e;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    bit          ok;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observable PC-update or decode-valid cycle must match the next expected event.
    always @(negedge clk) begin
        if (instr_valid || pc_en) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_event cyc=%0d got v=%b en=%b src=%b tgt=%h out=%h pc=%h cnt=%h required no event",
                         cyc, instr_valid, pc_en, pc_src, pc_target, instr_out, instr_pc, fetch_count);
            end else begin
                e  = sb.pop_front();
                ok = (e.cyc == cyc) && (e.v == instr_valid) && (e.en == pc_en) &&
                     (e.src == pc_src) && (e.cnt == fetch_count);
                if (e.src && (e.tgt != pc_target)) ok = 1'b0;
                if (e.v && ((e.out != instr_out) || (e.ipc != instr_pc))) ok = 1'b0;
                if (!ok) begin
                    n_mis++;
                    $display("FAIL event got cyc=%0d v=%b en=%b src=%b tgt=%h out=%h pc=%h cnt=%h required cyc=%0d v=%b en=%b src=%b tgt=%h out=%h pc=%h cnt=%h",
                             cyc, instr_valid, pc_en, pc_src, pc_target, instr_out, instr_pc, fetch_count,
                             e.cyc, e.v, e.en, e.src, e.tgt, e.out, e.ipc, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle's inputs, optionally expect an event, then advance the bench's PC register.
    task automatic step(input logic rdy, input logic [31:0] rd, input logic stl,
                        input logic rv, input logic [31:0] rt,
                        input logic hev, input logic v, input logic en, input logic src,
                        input logic [31:0] tgt, input logic [31:0] out,
                        input logic [31:0] ipc, input logic [31:0] cnt);
        ev_t x;
        logic s_en, s_src;
        logic [31:0] s_tgt;
        imem_ready = rdy; imem_rdata = rd; stall = stl;
        redirect_valid = rv; redirect_target = rt;
        if (hev) begin
            x.cyc = cyc; x.v = v; x.en = en; x.src = src;
            x.tgt = tgt; x.out = out; x.ipc = ipc; x.cnt = cnt;
            sb.push_back(x);
        end
        @(negedge clk);
        s_en = pc_en; s_src = pc_src; s_tgt = pc_target;
        @(posedge clk);
        #1;
        if (s_en) pc_in = s_src ? s_tgt : pc_in + 32'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        chk("reset_state_req", {31'd0, imem_req}, 32'd0);
        chk("reset_instr_out", instr_out, NOP_INSTR);
        chk("reset_count", fetch_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("idle_outputs", {instr_valid, pc_en, pc_src, imem_req, 28'd0} | imem_addr | instr_pc | pc_target, 32'd0);
        chk("idle_instr_out", instr_out, NOP_INSTR);
        step(0, 32'h0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Back-to-back consumed fetches
        step(1, 32'h11111111, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h11111111, 32'h0,  32'd0);
        step(1, 32'h22222222, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h22222222, 32'h4,  32'd1);
        step(1, 32'h33333333, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h33333333, 32'h8,  32'd2);

        // Stall parks the response in HOLD
        step(1, 32'h00500093, 1, 0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h00500093, 32'hC, 32'd3);
        #1 chk("hold_no_req", {31'd0, imem_req}, 32'd0);
        step(0, 32'hDEADBEEF, 1, 0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h00500093, 32'hC, 32'd3);
        step(0, 32'hDEADBEEF, 1, 0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h00500093, 32'hC, 32'd3);
        step(0, 32'hDEADBEEF, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h00500093, 32'hC, 32'd3);

        // Redirect while in flight: DROP until the beat retires
        step(0, 32'h0, 0, 1, 32'h100,      0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 chk("drop_req_held", {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h10);
        step(0, 32'h0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1, 32'hBADBAD00, 0, 0, 32'h0, 1, 0, 1, 1, 32'h100, 32'h0, 32'h0, 32'd4);

        // Latest redirect in DROP wins
        step(1, 32'h44444444, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h44444444, 32'h100, 32'd4);
        step(0, 32'h0, 0, 1, 32'h100,      0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(0, 32'h0, 0, 1, 32'h200,      0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1, 32'hBADBAD01, 0, 0, 32'h0, 1, 0, 1, 1, 32'h200, 32'h0, 32'h0, 32'd5);

        // Redirect on the retiring beat overrides the latched target
        step(0, 32'h0, 0, 1, 32'h300,      0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1, 32'hBADBAD02, 0, 1, 32'h340, 1, 0, 1, 1, 32'h340, 32'h0, 32'h0, 32'd5);

        // Redirect with a ready response drops that response
        step(1, 32'hBADBAD03, 0, 1, 32'h380, 1, 0, 1, 1, 32'h380, 32'h0, 32'h0, 32'd5);

        // Redirect during HOLD beats stall
        step(1, 32'h55555555, 1, 0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h55555555, 32'h380, 32'd5);
        step(0, 32'h0, 1, 1, 32'h40,       1, 0, 1, 1, 32'h40, 32'h0, 32'h0, 32'd5);
        step(1, 32'h66666666, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h66666666, 32'h40, 32'd5);

        // Counter wrap
        force dut.count_q = 32'hFFFFFFFF;
        #1 release dut.count_q;
        step(1, 32'h77777777, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h77777777, 32'h44, 32'hFFFFFFFF);
        imem_ready = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        #1 chk("count_wrapped", fetch_count, 32'd0);
        chk("req_addr", imem_addr, 32'h48);

        // Asynchronous reset mid-fetch
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ctrl", {28'd0, imem_req, instr_valid, pc_en, pc_src}, 32'd0);
        chk("async_rst_addr", imem_addr | instr_pc | pc_target, 32'd0);
        chk("async_rst_instr", instr_out, NOP_INSTR);
        chk("async_rst_count", fetch_count, 32'd0);
        @(posedge clk); #1;
        imem_ready = 1'b1; imem_rdata = 32'hBADBAD04;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 32'hBADBAD05, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1, 32'h88888888, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h88888888, 32'h48, 32'd0);

        // Redirect taken from IDLE
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 32'h0, 0, 1, 32'h500,      1, 0, 1, 1, 32'h500, 32'h0, 32'h0, 32'd0);
        step(1, 32'h99999999, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h99999999, 32'h500, 32'd0);
        step(0, 32'h0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("final_count", fetch_count, 32'd1);
        chk("events_pending", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_fetch_ctrl
